ir_assembler: RTL and testbench
===============================

Name: ir_assembler

Overview:
Parametrised instruction-register loader that assembles an IR_W-bit instruction word from DATA_W-bit beats on the shared data bus. It is the generalised successor of the fixed 2×8-bit loader: configurable width, beat count and byte order, with atomic commit, a completion pulse and abort reporting. It sits between the memory data bus and the controller/decoder, driven by the controller's load-IR enable.

Parameters:
DATA_W, 8, width of one data-bus beat
BEATS, 2, beats per instruction (>=1); IR_W = DATA_W*BEATS
MSB_FIRST, 1, 1 = first beat fills the most-significant slice; 0 = first beat fills the least-significant slice

Ports:
clk1  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-low
data  in  DATA_W  data-bus beat
ena  in  1  load-IR enable; one beat captured per cycle while high
opc_iraddr  out  IR_W  committed instruction word (opcode + address)
ir_valid  out  1  one-cycle pulse: opc_iraddr updated with a complete word this cycle
ir_abort  out  1  one-cycle pulse: partial load discarded
busy  out  1  partial word in progress (beat_idx != 0)
beat_idx  out  CNT_W  index of the next beat to capture; CNT_W = max(1, clog2(BEATS))

Behaviour:
- Reset (rst low, async): opc_iraddr=0, shadow=0, beat_idx=0, ir_valid=0, ir_abort=0, busy=0. Reset mid-load discards the partial word with no abort pulse.
- Slot mapping for beat k: MSB_FIRST=1 -> bits [IR_W-1-k*DATA_W -: DATA_W]; MSB_FIRST=0 -> bits [k*DATA_W +: DATA_W].
- ena=1, beat_idx<BEATS-1: data written into shadow slot beat_idx; beat_idx++.
- ena=1, beat_idx==BEATS-1: opc_iraddr <= shadow with the final slot taken from data in the same cycle; beat_idx<=0; ir_valid=1 on the following cycle (registered, coincident with the new opc_iraddr).
- ena=0, beat_idx!=0: beat_idx<=0; shadow contents ignored; opc_iraddr unchanged; ir_abort=1 on the following cycle.
- ena=0, beat_idx==0: idle, no change.
- ena held high continuously: one word committed every BEATS cycles; ir_valid pulses back-to-back when BEATS=1.
- BEATS=1: every ena cycle commits directly; busy is constantly 0; ir_abort never asserts.
- Latency: first beat to ir_valid = BEATS cycles.
- ir_valid and ir_abort are mutually exclusive and never held longer than one cycle.
- opc_iraddr holds its value between commits; no X is ever driven after reset.

Optional Feature:
IR_PARTIAL_VIS_EN
- Defined: legacy-compatible in-place loading. Each beat is written directly into its opc_iraddr slot in the capture cycle, with no shadow register. On abort, opc_iraddr keeps the partially updated value. ir_valid and ir_abort pulse as in the base behaviour.
- Undefined (default): atomic commit through the shadow register as specified above.

Decomposition:
- Package ir_pkg: MSB_FIRST/LSB_FIRST constants, the CNT_W derivation function, and a slot-offset function (beat index, DATA_W, BEATS, order) -> low bit.
- One sub-module: ir_beat_decoder. Combinational, beat_idx -> one-hot slice-enable vector (BEATS bits) honouring MSB_FIRST. Reused by both the shadow and the in-place paths.

Test Plan:
1. Defaults; ena=1 for 2 cycles with data 0xA5 then 0x3C -> opc_iraddr=0xA53C and ir_valid=1 in cycle 3; beat_idx sequence 0,1,0.
2. MSB_FIRST=0, DATA_W=8, BEATS=4; beats 0x11,0x22,0x33,0x44 -> opc_iraddr=0x44332211; single ir_valid pulse 4 cycles after the first beat.
3. Defaults; ena high for 1 beat (0xFF), then low -> ir_abort pulses once, opc_iraddr keeps its prior value 0xA53C, busy drops. With IR_PARTIAL_VIS_EN defined -> opc_iraddr=0xFF3C.
4. ena held for 6 cycles with beats 0x01..0x06 -> commits 0x0102, 0x0304, 0x0506; three ir_valid pulses, no ir_abort.
5. rst driven low asynchronously between clock edges mid-load after beat 0x77 -> all outputs 0 immediately, no ir_abort. After release, a fresh 2-beat load 0x12,0x34 -> 0x1234.
6. BEATS=1, DATA_W=16; ena=1 with 0xBEEF then 0xCAFE -> two consecutive ir_valid pulses with opc_iraddr 0xBEEF then 0xCAFE; busy stays 0.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared constants and helpers for the instruction-register assembler:
// byte-order selectors, counter-width derivation and beat-to-slice mapping.
package ir_pkg;

  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  // Beat counter width; a single-beat word still needs a 1-bit index port.
  function automatic int cnt_w(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  // Low bit of the slice filled by beat k. With data_w=1 this yields the slice number.
  function automatic int slot_lo(input int k, input int data_w, input int beats,
                                 input bit msb_first);
    return msb_first ? (beats - 1 - k) * data_w : k * data_w;
  endfunction

endpackage

// File: rtl/ir_assembler_if.sv
// Data-bus / controller side signals of the IR assembler. The master modport is the
// controller driving beats; the slave modport is the assembler.
interface ir_assembler_if
  import ir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BEATS  = 2
);
  localparam int IR_W  = DATA_W * BEATS;
  localparam int CNT_W = cnt_w(BEATS);

  logic [DATA_W-1:0] data;
  logic              ena;
  logic [IR_W-1:0]   opc_iraddr;
  logic              ir_valid;
  logic              ir_abort;
  logic              busy;
  logic [CNT_W-1:0]  beat_idx;

  modport master (
    output data, ena,
    input  opc_iraddr, ir_valid, ir_abort, busy, beat_idx
  );

  modport slave (
    input  data, ena,
    output opc_iraddr, ir_valid, ir_abort, busy, beat_idx
  );

endinterface

// File: rtl/ir_beat_decoder.sv
// Maps the current beat index to a one-hot enable over the physical word slices
// (bit j = bits [j*DATA_W +: DATA_W]), honouring the configured byte order.
module ir_beat_decoder
  import ir_pkg::*;
#(
  parameter int BEATS     = 2,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST,
  parameter int CNT_W     = cnt_w(BEATS)
) (
  input  logic [CNT_W-1:0] beat_idx_i,
  output logic [BEATS-1:0] slot_en_o
);

  // NOTE: default assigned first so every path through the block drives the
  // output and no latch is inferred.
  always_comb begin
    slot_en_o = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_idx_i == CNT_W'(k)) slot_en_o[slot_lo(k, 1, BEATS, MSB_FIRST)] = 1'b1;
    end
  end

endmodule

// File: rtl/ir_assembler.sv
// Instruction-register loader: assembles DATA_W*BEATS-bit words from bus beats with
// atomic commit; define IR_PARTIAL_VIS_EN for legacy in-place loading without a shadow.
module ir_assembler
  import ir_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BEATS     = 2,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic          clk1,
  input  logic          rst,
  ir_assembler_if.slave bus
);

  localparam int IR_W  = DATA_W * BEATS;
  localparam int CNT_W = cnt_w(BEATS);

  logic [IR_W-1:0]  opc_q, opc_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic [BEATS-1:0] slot_en;
  logic [IR_W-1:0]  base;
  logic [IR_W-1:0]  merged;
  logic             last_beat;

  ir_beat_decoder #(
    .BEATS     (BEATS),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_dec (
    .beat_idx_i (idx_q),
    .slot_en_o  (slot_en)
  );

`ifdef IR_PARTIAL_VIS_EN
  // Beats land directly in the visible register, so a merge starts from it.
  assign base = opc_q;
`else
  logic [IR_W-1:0] shadow_q, shadow_d;
  assign base = shadow_q;
`endif

  assign last_beat = (idx_q == CNT_W'(BEATS - 1));

  always_comb begin
    merged = base;
    for (int j = 0; j < BEATS; j++) begin
      if (slot_en[j]) merged[j*DATA_W +: DATA_W] = bus.data;
    end
  end

  always_comb begin
    opc_d   = opc_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
`ifndef IR_PARTIAL_VIS_EN
    shadow_d = shadow_q;
`endif
    if (bus.ena) begin
      if (last_beat) begin
        // Final slot comes straight from the bus, so the commit costs no extra cycle.
        opc_d   = merged;
        idx_d   = '0;
        valid_d = 1'b1;
      end else begin
`ifdef IR_PARTIAL_VIS_EN
        opc_d    = merged;
`else
        shadow_d = merged;
`endif
        idx_d    = idx_q + CNT_W'(1);
      end
    end else if (idx_q != '0) begin
      idx_d   = '0;
      abort_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      opc_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      abort_q  <= 1'b0;
`ifndef IR_PARTIAL_VIS_EN
      shadow_q <= '0;
`endif
    end else begin
      opc_q    <= opc_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
`ifndef IR_PARTIAL_VIS_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign bus.opc_iraddr = opc_q;
  assign bus.ir_valid   = valid_q;
  assign bus.ir_abort   = abort_q;
  assign bus.busy       = (idx_q != '0);
  assign bus.beat_idx   = idx_q;

endmodule

// File: tb/tb_ir_assembler.sv
// Bench for ir_assembler: three configurations driven from one beat stream and checked
// cycle by cycle against a word-level model built from collected beats.
module tb_ir_assembler;

  logic clk1 = 1'b0;
  logic rst  = 1'b0;
  always #5 clk1 = ~clk1;

  ir_assembler_if #(.DATA_W(8),  .BEATS(2)) b0 ();
  ir_assembler_if #(.DATA_W(8),  .BEATS(4)) b1 ();
  ir_assembler_if #(.DATA_W(16), .BEATS(1)) b2 ();

  ir_assembler #(.DATA_W(8),  .BEATS(2), .MSB_FIRST(1'b1)) dut0 (.clk1(clk1), .rst(rst), .bus(b0));
  ir_assembler #(.DATA_W(8),  .BEATS(4), .MSB_FIRST(1'b0)) dut1 (.clk1(clk1), .rst(rst), .bus(b1));
  ir_assembler #(.DATA_W(16), .BEATS(1), .MSB_FIRST(1'b1)) dut2 (.clk1(clk1), .rst(rst), .bus(b2));

  int dw_a[3]  = '{8, 8, 16};
  int nb_a[3]  = '{2, 4, 1};
  bit msb_a[3] = '{1'b1, 1'b0, 1'b1};

  int          m_cnt[3];
  logic [31:0] m_word[3];
  logic [31:0] m_beats[3][4];
  bit          m_valid[3];
  bit          m_abort[3];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_word[i] = '0; m_valid[i] = 0; m_abort[i] = 0;
    end
  endtask

  // Word-level behaviour: collect beats; on the last one build the word arithmetically.
  task automatic model_step(input bit ena, input logic [15:0] d);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] mask, beat, w;
      int pos;
      mask = (32'd1 << dw_a[i]) - 32'd1;
      beat = {16'd0, d} & mask;
      m_valid[i] = 0;
      m_abort[i] = 0;
      if (ena) begin
`ifdef IR_PARTIAL_VIS_EN
        pos = msb_a[i] ? (nb_a[i] - 1 - m_cnt[i]) * dw_a[i] : m_cnt[i] * dw_a[i];
        m_word[i] = (m_word[i] & ~(mask << pos)) | (beat << pos);
`endif
        m_beats[i][m_cnt[i]] = beat;
        m_cnt[i]++;
        if (m_cnt[i] == nb_a[i]) begin
          w = '0;
          for (int k = 0; k < nb_a[i]; k++) begin
            if (msb_a[i]) w = (w << dw_a[i]) | m_beats[i][k];
            else          w = w | (m_beats[i][k] << (k * dw_a[i]));
          end
          m_word[i]  = w;
          m_cnt[i]   = 0;
          m_valid[i] = 1;
        end
      end else if (m_cnt[i] != 0) begin
        m_cnt[i]   = 0;
        m_abort[i] = 1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [31:0] opc[3], idx[3];
    logic        vld[3], abt[3], bsy[3];
    opc[0] = 32'(b0.opc_iraddr); idx[0] = 32'(b0.beat_idx);
    vld[0] = b0.ir_valid; abt[0] = b0.ir_abort; bsy[0] = b0.busy;
    opc[1] = 32'(b1.opc_iraddr); idx[1] = 32'(b1.beat_idx);
    vld[1] = b1.ir_valid; abt[1] = b1.ir_abort; bsy[1] = b1.busy;
    opc[2] = 32'(b2.opc_iraddr); idx[2] = 32'(b2.beat_idx);
    vld[2] = b2.ir_valid; abt[2] = b2.ir_abort; bsy[2] = b2.busy;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s d%0d opc", ph, i),   opc[i], m_word[i]);
      check($sformatf("%s d%0d valid", ph, i), 32'(vld[i]), 32'(m_valid[i]));
      check($sformatf("%s d%0d abort", ph, i), 32'(abt[i]), 32'(m_abort[i]));
      check($sformatf("%s d%0d busy", ph, i),  32'(bsy[i]), 32'(m_cnt[i] != 0));
      check($sformatf("%s d%0d idx", ph, i),   idx[i], 32'(m_cnt[i]));
    end
  endtask

  task automatic drive(input bit ena, input logic [15:0] d);
    b0.ena = ena; b0.data = d[7:0];
    b1.ena = ena; b1.data = d[7:0];
    b2.ena = ena; b2.data = d;
  endtask

  task automatic step(input string ph, input bit ena, input logic [15:0] d);
    @(negedge clk1);
    drive(ena, d);
    model_step(ena, d);
    @(posedge clk1);
    #1;
    check_all(ph);
  endtask

  initial begin
    drive(1'b0, 16'd0);
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk1);
    rst = 1'b1;

    // Two-beat MSB-first word, then a one-beat abort.
    step("t1a", 1'b1, 16'h00A5);
    step("t1b", 1'b1, 16'h003C);
    step("t1c", 1'b0, 16'h0000);
    step("t3a", 1'b1, 16'h00FF);
    step("t3b", 1'b0, 16'h0000);
    step("t3c", 1'b0, 16'h0000);

    // Four-beat LSB-first word; default instance commits twice on the same stream.
    step("t2a", 1'b1, 16'h0011);
    step("t2b", 1'b1, 16'h0022);
    step("t2c", 1'b1, 16'h0033);
    step("t2d", 1'b1, 16'h0044);
    step("t2e", 1'b0, 16'h0000);

    // Continuous enable across three commits.
    for (int k = 1; k <= 6; k++) step($sformatf("t4_%0d", k), 1'b1, 16'(k));
    step("t4z", 1'b0, 16'h0000);

    // Asynchronous reset between edges in the middle of a load.
    step("t5a", 1'b1, 16'h0077);
    #2;
    rst = 1'b0;
    drive(1'b0, 16'd0);
    model_reset();
    #1;
    check_all("t5rst");
    @(negedge clk1);
    rst = 1'b1;
    step("t5b", 1'b1, 16'h0012);
    step("t5c", 1'b1, 16'h0034);
    step("t5d", 1'b0, 16'h0000);

    // Single-beat wide word, back-to-back commits.
    step("t6a", 1'b1, 16'hBEEF);
    step("t6b", 1'b1, 16'hCAFE);
    step("t6c", 1'b0, 16'h0000);

    // Randomised enable and data.
    for (int n = 0; n < 400; n++) begin
      step("rnd", ($urandom_range(0, 9) < 7), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
